// File: rtl/uart_reg_responder_if.sv
// Byte-stream handshake between a UART receiver/transmitter pair and the
// register responder. Signal suffixes are from the responder's point of view.
interface uart_reg_responder_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] rx_dat_i;
    logic             rx_new_i;
    logic             tx_rdy_i;
    logic [WIDTH-1:0] tx_dat_o;
    logic             tx_new_o;

    modport master (
        output rx_dat_i, rx_new_i, tx_rdy_i,
        input  tx_dat_o, tx_new_o
    );

    modport slave (
        input  rx_dat_i, rx_new_i, tx_rdy_i,
        output tx_dat_o, tx_new_o
    );
endinterface

// File: rtl/uart_reg_responder.sv
// Command/response register file behind a UART: a command byte (bit7 = write,
// bits[6:0] = address) optionally followed by a data byte yields one reply byte.
module uart_reg_responder #(
    parameter int WIDTH   = 8,
    parameter int NREGS   = 16,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    uart_reg_responder_if.slave    bus,
    output logic [NREGS*WIDTH-1:0] regs_o,
    output logic                   busy_o,
    output logic                   err_o
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WIDTH-1:0] ACK = WIDTH'(8'h06);
    localparam logic [WIDTH-1:0] NAK = WIDTH'(8'h15);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GET_DATA = 2'd1,
        RESP     = 2'd2,
        WAIT_TX  = 2'd3
    } state_e;

    state_e                        state_q, state_d;
    logic                          wr_q, wr_d;
    logic [6:0]                    addr_q, addr_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic [NREGS-1:0][WIDTH-1:0]   regs_q, regs_d;
    logic [WIDTH-1:0]              tx_dat_q, tx_dat_d;
    logic                          tx_new_q, tx_new_d;
    logic                          busy_q, busy_d;
    logic                          err_q, err_d;

    logic                          addr_ok;
    logic [WIDTH-1:0]              rd_byte;
    logic [WIDTH-1:0]              resp_byte;

    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        regs_d   = regs_q;
        tx_dat_d = tx_dat_q;
        tx_new_d = 1'b0;
        err_d    = 1'b0;

        addr_ok = (int'(addr_q) < NREGS);
        rd_byte = '0;
        for (int k = 0; k < NREGS; k++) begin
            if (int'(addr_q) == k) rd_byte = regs_q[k];
        end
        resp_byte = !addr_ok ? NAK : (wr_q ? ACK : rd_byte);

        case (state_q)
            IDLE: begin
                if (bus.rx_new_i) begin
                    wr_d    = bus.rx_dat_i[7];
                    addr_d  = bus.rx_dat_i[6:0];
                    cnt_d   = '0;
                    state_d = bus.rx_dat_i[7] ? GET_DATA : RESP;
                end
            end
            GET_DATA: begin
                // A byte arriving on the timeout edge still counts as the data byte.
                if (bus.rx_new_i) begin
                    for (int k = 0; k < NREGS; k++) begin
                        if (int'(addr_q) == k) regs_d[k] = bus.rx_dat_i;
                    end
                    cnt_d   = '0;
                    state_d = RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                err_d = bus.rx_new_i;
                if (bus.tx_rdy_i) begin
                    tx_dat_d = resp_byte;
                    tx_new_d = 1'b1;
                    state_d  = WAIT_TX;
                end
            end
            WAIT_TX: begin
                err_d = bus.rx_new_i;
                if (!bus.tx_rdy_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: the register file is reset along with the control state because its contents are visible on regs_o.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            cnt_q    <= '0;
            regs_q   <= '0;
            tx_dat_q <= '0;
            tx_new_q <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            regs_q   <= regs_d;
            tx_dat_q <= tx_dat_d;
            tx_new_q <= tx_new_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    assign bus.tx_dat_o = tx_dat_q;
    assign bus.tx_new_o = tx_new_q;
    assign regs_o       = regs_q;
    assign busy_o       = busy_q;
    assign err_o        = err_q;

endmodule

// File: doc/uart_reg_responder.md
UART_REG_RESPONDER -- requirements
Module: uart_reg_responder

Interface
REQ-001 SHALL have parameter WIDTH, default 8: byte width of the rx, tx and register data.
REQ-002 SHALL have parameter NREGS, default 16: number of registers, range 1..128.
REQ-003 SHALL have parameter TIMEOUT, default 1_000_000: maximum clk_i cycles allowed between command byte and data byte.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port rx_dat_i, input, WIDTH bits: received byte, valid when rx_new_i=1.
REQ-007 SHALL have port rx_new_i, input, 1 bit: one-cycle strobe marking a received byte.
REQ-008 SHALL have port tx_rdy_i, input, 1 bit: transmitter idle; level.
REQ-009 SHALL have port tx_dat_o, output, WIDTH bits: byte for the transmitter; held stable until tx_rdy_i falls.
REQ-010 SHALL have port tx_new_o, output, 1 bit: one-cycle send strobe.
REQ-011 SHALL have port regs_o, output, NREGS*WIDTH bits: flat register file, register k at bits [k*WIDTH +: WIDTH].
REQ-012 SHALL have port busy_o, output, 1 bit: high in every state except IDLE.
REQ-013 SHALL have port err_o, output, 1 bit: one-cycle pulse on overrun or timeout.

Function
REQ-014 SHALL decode command byte fields as: bit7 = write (1) or read (0); bits[6:0] = address.
REQ-015 SHALL implement FSM states IDLE, GET_DATA, RESP and WAIT_TX, all outputs registered.
REQ-016 SHALL, in IDLE with rx_new_i=1: latch the command; go to GET_DATA for a write, or to RESP for a read.
REQ-017 SHALL, in GET_DATA with rx_new_i=1: if address < NREGS, write rx_dat_i to that register on that same edge; either way go to RESP.
REQ-018 SHALL select the response byte as: read with valid address -> register contents; write with valid address -> 0x06 (ACK); address >= NREGS -> 0x15 (NAK), for both reads and writes.
REQ-019 SHALL, in RESP on the first edge with tx_rdy_i=1: load tx_dat_o, pulse tx_new_o for exactly 1 cycle, and go to WAIT_TX; RESP waits indefinitely while tx_rdy_i=0.
REQ-020 SHALL, in WAIT_TX, go to IDLE on the first edge that samples tx_rdy_i=0.
REQ-021 SHALL give a latency of 2 edges from the edge sampling the final request byte to tx_new_o=1, when tx_rdy_i is already 1.
REQ-022 SHALL time out in GET_DATA: count cycles without rx_new_i; when the count reaches TIMEOUT, go to IDLE, pulse err_o, send no response and write no register; the counter clears on entering GET_DATA.
REQ-023 SHALL handle overrun: rx_new_i=1 in RESP or WAIT_TX drops the byte, pulses err_o, and leaves state and response unaffected.
REQ-024 SHALL, when rx_new_i=1 and a timeout occur on the same edge, give priority to the byte: it is treated as the data byte and no err_o pulse is generated.
REQ-025 SHALL let a back-to-back command, whose strobe arrives on the cycle IDLE is re-entered, be accepted normally.
REQ-026 SHALL treat any unused state encoding as IDLE on the next edge.

Reset
REQ-027 SHALL, while rst_i=0, immediately force: state to IDLE, all registers to 0, tx_dat_o to 0, tx_new_o to 0, busy_o to 0, err_o to 0, and the timeout counter to 0.
REQ-028 SHALL, on reset assertion mid-transaction, abandon the transaction without sending a response; a write is not performed unless its data edge preceded the reset.
REQ-029 SHALL recognise the first rx_new_i no earlier than the first rising edge after rst_i rises.

Verification
REQ-030 SHALL verify write then read: send bytes 0x83, 0x5A -> tx byte 0x06, regs_o[31:24]=0x5A; then send 0x03 -> tx byte 0x5A.
REQ-031 SHALL verify an invalid address with NREGS=16: send 0x20 -> tx 0x15; send 0x90, 0x11 -> tx 0x15, and regs_o is unchanged.
REQ-032 SHALL verify timeout with TIMEOUT=100: send 0x81, then no byte for 100 cycles -> err_o pulses once, no tx_new_o, register 1 stays 0, and busy_o=0.
REQ-033 SHALL verify backpressure: hold tx_rdy_i=0 for 50 cycles after a read -> no tx_new_o; raise tx_rdy_i -> tx_new_o pulses exactly once, 1 edge later.
REQ-034 SHALL verify overrun: send a byte during WAIT_TX -> err_o pulse, and the original response is delivered unaltered.
REQ-035 SHALL verify reset mid-write: drop rst_i in GET_DATA -> all outputs are 0 immediately, and a subsequent read of that register returns 0x00.
